// File: rtl/melody_seq_pkg.sv
// Shared definitions for the melody sequencer: state encoding, note
// half-period and duration constants for a 50 MHz clock, song index width helper.
// Latency: n/a (definitions only). Backpressure: n/a.
package melody_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_PLAY  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Half-periods in clk cycles (50 MHz / (2 * f)); 0 encodes a rest.
  localparam logic [27:0] DO    = 28'd95556;
  localparam logic [27:0] RE    = 28'd85131;
  localparam logic [27:0] MI    = 28'd75843;
  localparam logic [27:0] FA    = 28'd71586;
  localparam logic [27:0] SOL   = 28'd63776;
  localparam logic [27:0] LA    = 28'd56818;
  localparam logic [27:0] SI    = 28'd50619;
  localparam logic [27:0] DO_4  = 28'd47778;
  localparam logic [27:0] RE_4  = 28'd42566;
  localparam logic [27:0] MI_4  = 28'd37922;
  localparam logic [27:0] FA_4  = 28'd35793;
  localparam logic [27:0] SOL_4 = 28'd31888;
  localparam logic [27:0] REST  = 28'd0;

  // Durations in clk cycles at 120 bpm.
  localparam logic [27:0] N2  = 28'd50000000;
  localparam logic [27:0] N4  = 28'd25000000;
  localparam logic [27:0] N8  = 28'd12500000;
  localparam logic [27:0] ND2 = 28'd75000000;
  localparam logic [27:0] GAP = 28'd2500000;

  // Song index width; never below 1 so a single-song build still has a port.
  function automatic int song_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/melody_debounce.sv
// Push-button debouncer: 2-flop synchroniser, DEB_LEN sample shift register,
// single-cycle press pulse. Latency: press_o 2+DEB_LEN cycles after a stable high.
// Backpressure: none.
//   clk, reset : clock, async active-high reset
//   pb_i       : raw button level
//   press_o    : one-cycle pulse per debounced press
module melody_debounce #(
  parameter int DEB_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic pb_i,
  output logic press_o
);

  logic [1:0]         sync_q;
  logic [DEB_LEN-1:0] shift_q;
  logic               full_q;
  logic               full_d;

  assign full_d = &shift_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      shift_q <= '0;
      full_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], pb_i};
      shift_q <= {shift_q[DEB_LEN-2:0], sync_q[1]};
      full_q  <= full_d;
    end
  end

  // Rising edge of the all-ones condition: one pulse however long the button is held.
  assign press_o = full_d & ~full_q;

endmodule

// File: rtl/melody_seq.sv
// Multi-song melody sequencer: walks (tone, dur, last) entries of an external
// synchronous note ROM and drives a square-wave speaker.
// Latency: en high at cycle 0 -> PLAY at cycle 3; 2 cycles between notes. Backpressure: none.
//   clk, reset             : clock, async active-high reset
//   en, next_pb, loop_en   : play enable, raw song-select button, loop mode
//   rom_song/rom_addr      : ROM read address (song, note)
//   rom_tone/dur/last      : ROM data, valid one cycle after the address
//   spk, amp_en            : speaker wave, amplifier enable
//   playing, song_done     : activity flag, end-of-song pulse
//   cur_song               : selected song
module melody_seq
  import melody_seq_pkg::*;
#(
  parameter int NUM_SONGS = 2,
  parameter int ADDR_W    = 8,
  parameter int TONE_W    = 28,
  parameter int DUR_W     = 28,
  parameter int DEB_LEN   = 8,
  parameter int SONG_W    = song_width(NUM_SONGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              next_pb,
  input  logic              loop_en,
  output logic [SONG_W-1:0] rom_song,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [TONE_W-1:0] rom_tone,
  input  logic [DUR_W-1:0]  rom_dur,
  input  logic              rom_last,
  output logic              spk,
  output logic [1:0]        amp_en,
  output logic              playing,
  output logic              song_done,
  output logic [SONG_W-1:0] cur_song
);

  state_t            state_q;
  logic [SONG_W-1:0] song_q, song_d;
  logic [ADDR_W-1:0] addr_q;
  logic [TONE_W-1:0] tone_cnt_q, tone_last_q;
  logic [DUR_W-1:0]  dur_cnt_q, dur_last_q;
  logic              rest_q, last_q;
  logic              spk_q, playing_q, done_q;
  logic [1:0]        amp_q;
  logic              press;

  melody_debounce #(.DEB_LEN(DEB_LEN)) u_deb (
    .clk     (clk),
    .reset   (reset),
    .pb_i    (next_pb),
    .press_o (press)
  );

  assign song_d = (song_q == SONG_W'(NUM_SONGS - 1)) ? '0 : song_q + SONG_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      song_q      <= '0;
      addr_q      <= '0;
      tone_cnt_q  <= '0;
      tone_last_q <= '0;
      dur_cnt_q   <= '0;
      dur_last_q  <= '0;
      rest_q      <= 1'b0;
      last_q      <= 1'b0;
      spk_q       <= 1'b0;
      playing_q   <= 1'b0;
      done_q      <= 1'b0;
      amp_q       <= 2'b00;
    end else begin
      amp_q  <= 2'b01;
      done_q <= 1'b0;
      // Song selection works regardless of enable; playback state follows below.
      if (press) song_q <= song_d;

      if (!en) begin
        state_q    <= S_IDLE;
        addr_q     <= '0;
        tone_cnt_q <= '0;
        dur_cnt_q  <= '0;
        spk_q      <= 1'b0;
        playing_q  <= 1'b0;
      end else if (press) begin
        // Restart from note 0 of the newly selected song; beats a coincident note end.
        state_q    <= S_FETCH;
        addr_q     <= '0;
        tone_cnt_q <= '0;
        dur_cnt_q  <= '0;
        spk_q      <= 1'b0;
        playing_q  <= 1'b1;
      end else begin
        case (state_q)
          S_IDLE: begin
            state_q   <= S_FETCH;
            playing_q <= 1'b1;
          end
          // ROM samples rom_addr at the end of FETCH; data is on the bus during LOAD.
          S_FETCH: state_q <= S_LOAD;
          S_LOAD: begin
            rest_q      <= (rom_tone == '0);
            tone_last_q <= rom_tone - TONE_W'(1);
            dur_last_q  <= (rom_dur == '0) ? '0 : rom_dur - DUR_W'(1);
            last_q      <= rom_last;
            tone_cnt_q  <= '0;
            dur_cnt_q   <= '0;
            spk_q       <= 1'b0;
            state_q     <= S_PLAY;
          end
          S_PLAY: begin
            if (dur_cnt_q == dur_last_q) begin
              spk_q      <= 1'b0;
              tone_cnt_q <= '0;
              dur_cnt_q  <= '0;
              if (last_q) begin
                done_q <= 1'b1;
                if (loop_en) begin
                  addr_q  <= '0;
                  state_q <= S_FETCH;
                end else begin
                  state_q   <= S_DONE;
                  playing_q <= 1'b0;
                end
              end else begin
                // Natural wrap at 2^ADDR_W-1 back to 0.
                addr_q  <= addr_q + ADDR_W'(1);
                state_q <= S_FETCH;
              end
            end else begin
              dur_cnt_q <= dur_cnt_q + DUR_W'(1);
              if (rest_q) begin
                spk_q      <= 1'b0;
                tone_cnt_q <= '0;
              end else if (tone_cnt_q == tone_last_q) begin
                tone_cnt_q <= '0;
                spk_q      <= ~spk_q;
              end else begin
                tone_cnt_q <= tone_cnt_q + TONE_W'(1);
              end
            end
          end
          // Left only by en falling or a button press, both handled above.
          S_DONE:  state_q <= S_DONE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign rom_song  = song_q;
  assign cur_song  = song_q;
  assign rom_addr  = addr_q;
  assign spk       = spk_q;
  assign amp_en    = amp_q;
  assign playing   = playing_q;
  assign song_done = done_q;

endmodule

// File: tb/tb_melody_seq.sv
module tb_melody_seq;

  logic        clk;
  logic        reset;
  logic        en;
  logic        next_pb;
  logic        loop_en;
  logic [1:0]  rom_song;
  logic [7:0]  rom_addr;
  logic [27:0] rom_tone;
  logic [27:0] rom_dur;
  logic        rom_last;
  logic        spk;
  logic [1:0]  amp_en;
  logic        playing;
  logic        song_done;
  logic [1:0]  cur_song;

  melody_seq #(
    .NUM_SONGS (3),
    .ADDR_W    (8),
    .TONE_W    (28),
    .DUR_W     (28),
    .DEB_LEN   (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .next_pb   (next_pb),
    .loop_en   (loop_en),
    .rom_song  (rom_song),
    .rom_addr  (rom_addr),
    .rom_tone  (rom_tone),
    .rom_dur   (rom_dur),
    .rom_last  (rom_last),
    .spk       (spk),
    .amp_en    (amp_en),
    .playing   (playing),
    .song_done (song_done),
    .cur_song  (cur_song)
  );

  // Signal ids for the scoreboard
  localparam int SPK = 0, PLY = 1, DN = 2, ADR = 3, CUR = 4, AMP = 5, RSG = 6;

  typedef struct {
    int          cyc;
    int          sig;
    int          val;
    logic [95:0] nm;
  } exp_t;

  exp_t exp_q[$];
  int   done_q[$];
  int   rise_q[$];
  bit   rise_chk;
  logic spk_prev;
  int   cyc;
  int   n_cmp;
  int   n_bad;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous note ROM model
  function automatic logic [56:0] rom_entry(input logic [1:0] s, input logic [7:0] a);
    logic [56:0] e;
    e = {28'd0, 28'd1, 1'b1};
    if (s == 2'd0 && a == 8'd0) e = {28'd4, 28'd40, 1'b0};
    if (s == 2'd0 && a == 8'd1) e = {28'd0, 28'd10, 1'b1};
    if (s == 2'd1 && a == 8'd0) e = {28'd3, 28'd6, 1'b1};
    if (s == 2'd2 && a == 8'd0) e = {28'd2, 28'd4, 1'b1};
    return e;
  endfunction

  always @(posedge clk) {rom_tone, rom_dur, rom_last} <= rom_entry(rom_song, rom_addr);

  function automatic int sig_val(input int s);
    case (s)
      SPK:     return int'(spk);
      PLY:     return int'(playing);
      DN:      return int'(song_done);
      ADR:     return int'(rom_addr);
      CUR:     return int'(cur_song);
      AMP:     return int'(amp_en);
      default: return int'(rom_song);
    endcase
  endfunction

  task automatic expect_at(input int c, input int s, input int v, input logic [95:0] nm);
    exp_q.push_back('{c, s, v, nm});
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) tick(1);
  endtask

  task automatic drop_en();
    int c;
    c = cyc;
    en = 1'b0;
    expect_at(c + 1, PLY, 0, "drop_playing");
    expect_at(c + 1, SPK, 0, "drop_spk");
    expect_at(c + 1, ADR, 0, "drop_addr");
  endtask

  // Monitor: compares every scheduled expectation in its cycle, every song_done
  // pulse against the expected pulse cycles, and spk rising edges when enabled.
  always @(negedge clk) begin : mon
    int got;
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].cyc <= cyc) begin
        got = sig_val(exp_q[i].sig);
        n_cmp = n_cmp + 1;
        if (exp_q[i].cyc != cyc || got != exp_q[i].val) begin
          n_bad = n_bad + 1;
          $display("FAIL %0s cyc=%0d (due %0d) got=%0d exp=%0d",
                   exp_q[i].nm, cyc, exp_q[i].cyc, got, exp_q[i].val);
        end
        exp_q.delete(i);
      end
    end
    if (song_done === 1'b1) begin
      n_cmp = n_cmp + 1;
      if (done_q.size() == 0) begin
        n_bad = n_bad + 1;
        $display("FAIL song_done unexpected pulse at cyc=%0d", cyc);
      end else begin
        got = done_q.pop_front();
        if (got != cyc) begin
          n_bad = n_bad + 1;
          $display("FAIL song_done pulse at cyc=%0d exp=%0d", cyc, got);
        end
      end
    end
    if (rise_chk && spk === 1'b1 && spk_prev === 1'b0) begin
      n_cmp = n_cmp + 1;
      if (rise_q.size() == 0) begin
        n_bad = n_bad + 1;
        $display("FAIL spk_rise unexpected at cyc=%0d", cyc);
      end else begin
        got = rise_q.pop_front();
        if (got != cyc) begin
          n_bad = n_bad + 1;
          $display("FAIL spk_rise at cyc=%0d exp=%0d", cyc, got);
        end
      end
    end
    spk_prev <= spk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int b, p, e, r, k;
    cyc = 0; n_cmp = 0; n_bad = 0; rise_chk = 1'b0;
    en = 1'b0; next_pb = 1'b0; loop_en = 1'b0; reset = 1'b0;
    #1 reset = 1'b1;

    // Reset state
    tick(3);
    expect_at(cyc, SPK, 0, "rst_spk");
    expect_at(cyc, PLY, 0, "rst_playing");
    expect_at(cyc, DN,  0, "rst_done");
    expect_at(cyc, ADR, 0, "rst_addr");
    expect_at(cyc, CUR, 0, "rst_cur_song");
    expect_at(cyc, RSG, 0, "rst_rom_song");
    expect_at(cyc, AMP, 0, "rst_amp_en");
    reset = 1'b0;
    expect_at(cyc + 1, AMP, 1, "amp_en_run");
    tick(3);

    // 1: one-shot song0, tone 4 x 40 cycles then rest 10 cycles
    b = cyc; en = 1'b1; rise_chk = 1'b1;
    expect_at(b,      PLY, 0, "t1_idle");
    expect_at(b + 1,  PLY, 1, "t1_fetch");
    expect_at(b + 3,  PLY, 1, "t1_play");
    expect_at(b + 3,  SPK, 0, "t1_spk3");
    expect_at(b + 6,  SPK, 0, "t1_spk6");
    expect_at(b + 7,  SPK, 1, "t1_spk7");
    expect_at(b + 10, SPK, 1, "t1_spk10");
    expect_at(b + 11, SPK, 0, "t1_spk11");
    expect_at(b + 39, SPK, 1, "t1_spk39");
    expect_at(b + 42, SPK, 1, "t1_spk42");
    expect_at(b + 42, ADR, 0, "t1_addr42");
    expect_at(b + 43, SPK, 0, "t1_spk_end");
    expect_at(b + 43, ADR, 1, "t1_addr43");
    expect_at(b + 50, SPK, 0, "t1_rest");
    expect_at(b + 54, PLY, 1, "t1_ply54");
    expect_at(b + 55, PLY, 0, "t1_done_ply");
    expect_at(b + 60, PLY, 0, "t1_done_hold");
    for (int i = 0; i < 5; i++) rise_q.push_back(b + 7 + 8 * i);
    done_q.push_back(b + 55);
    wait_cyc(b + 62);
    rise_chk = 1'b0;
    drop_en();
    tick(2);

    // 2: loop mode, song_done every 54 cycles
    loop_en = 1'b1;
    b = cyc; en = 1'b1;
    done_q.push_back(b + 55);
    done_q.push_back(b + 109);
    done_q.push_back(b + 163);
    expect_at(b + 54,  ADR, 1, "t2_addr54");
    expect_at(b + 55,  ADR, 0, "t2_addr_loop");
    expect_at(b + 55,  PLY, 1, "t2_ply_loop");
    expect_at(b + 57,  SPK, 0, "t2_spk57");
    expect_at(b + 61,  SPK, 1, "t2_spk61");
    expect_at(b + 115, SPK, 1, "t2_spk115");
    wait_cyc(b + 170);
    drop_en();
    tick(2);

    // 5: en dropped mid-note at dur_cnt 17, then again while spk high
    loop_en = 1'b0;
    b = cyc; en = 1'b1;
    expect_at(b + 18, SPK, 1, "t5_spk18");
    expect_at(b + 20, PLY, 1, "t5_ply20");
    wait_cyc(b + 20);
    drop_en();
    wait_cyc(b + 25);
    r = cyc; en = 1'b1;
    expect_at(r + 3,  PLY, 1, "t5_replay");
    expect_at(r + 6,  SPK, 0, "t5_spk6");
    expect_at(r + 7,  SPK, 1, "t5_spk7");
    expect_at(r + 31, SPK, 1, "t5_spk31");
    wait_cyc(r + 32);
    en = 1'b0;
    expect_at(r + 33, SPK, 0, "t5_spk_forced");
    expect_at(r + 33, PLY, 0, "t5_ply_off");
    tick(3);

    // 3: bouncing button while playing song0 -> one advance to song1
    b = cyc; en = 1'b1;
    wait_cyc(b + 10);
    for (int i = 0; i < 4; i++) begin
      next_pb = (i % 2 == 0);
      tick(1);
    end
    p = cyc; next_pb = 1'b1;
    expect_at(p + 6,  CUR, 0, "t3_cur_before");
    expect_at(p + 7,  CUR, 1, "t3_cur");
    expect_at(p + 7,  RSG, 1, "t3_rom_song");
    expect_at(p + 7,  ADR, 0, "t3_addr");
    expect_at(p + 7,  PLY, 1, "t3_fetch");
    expect_at(p + 13, SPK, 1, "t3_s1_spk");
    expect_at(p + 15, SPK, 0, "t3_s1_end");
    expect_at(p + 15, PLY, 0, "t3_s1_done");
    expect_at(p + 30, CUR, 1, "t3_one_adv");
    done_q.push_back(p + 15);
    tick(10);
    next_pb = 1'b0;
    wait_cyc(p + 31);

    // 6: async reset in the middle of a note
    drop_en();
    tick(2);
    e = cyc; en = 1'b1;
    expect_at(e + 3, PLY, 1, "t6_play");
    expect_at(e + 6, SPK, 1, "t6_spk_hi");
    wait_cyc(e + 7);
    #1 reset = 1'b1;
    en = 1'b0;
    expect_at(e + 7, SPK, 0, "t6_rst_spk");
    expect_at(e + 7, PLY, 0, "t6_rst_ply");
    expect_at(e + 7, AMP, 0, "t6_rst_amp");
    expect_at(e + 7, CUR, 0, "t6_rst_cur");
    expect_at(e + 7, ADR, 0, "t6_rst_addr");
    tick(2);
    reset = 1'b0;
    expect_at(e + 10, AMP, 1, "t6_amp_back");
    expect_at(e + 10, CUR, 0, "t6_cur_back");
    expect_at(e + 12, PLY, 0, "t6_idle");
    wait_cyc(e + 13);

    // 4: three presses with en=0 on a 3-song ROM
    for (k = 1; k <= 3; k++) begin
      p = cyc; next_pb = 1'b1;
      expect_at(p + 6, CUR, (k - 1) % 3, "t4_cur_prev");
      expect_at(p + 7, CUR, k % 3, "t4_cur");
      expect_at(p + 7, SPK, 0, "t4_spk");
      expect_at(p + 7, PLY, 0, "t4_ply");
      tick(8);
      next_pb = 1'b0;
      tick(8);
    end
    tick(5);

    while (exp_q.size() > 0) begin
      n_cmp = n_cmp + 1; n_bad = n_bad + 1;
      $display("FAIL %0s never checked (due %0d)", exp_q[0].nm, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    while (done_q.size() > 0) begin
      n_cmp = n_cmp + 1; n_bad = n_bad + 1;
      $display("FAIL song_done missing, exp cyc=%0d got none", done_q.pop_front());
    end
    while (rise_q.size() > 0) begin
      n_cmp = n_cmp + 1; n_bad = n_bad + 1;
      $display("FAIL spk_rise missing, exp cyc=%0d got none", rise_q.pop_front());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
